// File: rtl/inv_mix_columns_if.sv
// Handshake and data bundle for the iterative InvMixColumns stage.
// The master side requests a transform; the slave side (the stage) returns the result.
interface inv_mix_columns_if;
  logic         enableInvMixColumn;
  logic [127:0] value;
  logic [127:0] valueOut;
  logic         success;
  logic         busy;

  modport master (
    output enableInvMixColumn,
    output value,
    input  valueOut,
    input  success,
    input  busy
  );

  modport slave (
    input  enableInvMixColumn,
    input  value,
    output valueOut,
    output success,
    output busy
  );
endinterface

// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns: latches one state and transforms one column per
// falling clock edge, then publishes the result together with a one-cycle success pulse.
module inv_mix_columns (
  input  logic               clk,
  input  logic               reset,
  inv_mix_columns_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q,    state_d;
  logic [1:0]   col_q,      col_d;
  logic [127:0] work_q,     work_d;
  logic [127:0] valueOut_q, valueOut_d;
  logic         success_q,  success_d;
  logic         busy_q,     busy_d;
  logic [6:0]   col_base_s;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction

  // Single-byte inverse multiplier coefficients 09/0b/0d/0e share x2/x4/x8.
  function automatic logic [31:0] mul_set(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    // packed as {0e, 0b, 0d, 09}
    mul_set = {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [31:0] m0, m1, m2, m3;
    logic [7:0]  o0, o1, o2, o3;
    m0 = mul_set(c[31:24]);
    m1 = mul_set(c[23:16]);
    m2 = mul_set(c[15:8]);
    m3 = mul_set(c[7:0]);
    // field order inside mul_set: [31:24]=0e, [23:16]=0b, [15:8]=0d, [7:0]=09
    o0 = m0[31:24] ^ m1[23:16] ^ m2[15:8] ^ m3[7:0];
    o1 = m1[31:24] ^ m2[23:16] ^ m3[15:8] ^ m0[7:0];
    o2 = m2[31:24] ^ m3[23:16] ^ m0[15:8] ^ m1[7:0];
    o3 = m3[31:24] ^ m0[23:16] ^ m1[15:8] ^ m2[7:0];
    inv_col = {o0, o1, o2, o3};
  endfunction

  assign col_base_s = {col_q, 5'd0};

  // Next-state logic: accept in IDLE, one column per edge in RUN.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    work_d     = work_q;
    valueOut_d = valueOut_q;
    success_d  = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.enableInvMixColumn == 1'b1) begin
          work_d  = bus.value;
          col_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[col_base_s +: 32] = inv_col(work_q[col_base_s +: 32]);
        if (col_q == 2'd3) begin
          valueOut_d = work_d;
          success_d  = 1'b1;
          busy_d     = 1'b0;
          col_d      = 2'd0;
          state_d    = IDLE;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; the stage advances on the falling clock edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= 2'd0;
      work_q     <= 128'd0;
      valueOut_q <= 128'd0;
      success_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      work_q     <= work_d;
      valueOut_q <= valueOut_d;
      success_q  <= success_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.valueOut = valueOut_q;
  assign bus.success  = success_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed bench for inv_mix_columns: reset, known vector, MixColumns round trip,
// back-to-back, abort and idle-hold behaviour.
module tb_inv_mix_columns;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  inv_mix_columns_if bus_if ();

  inv_mix_columns dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] x);
    xt = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction

  // Forward MixColumns on one column: out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3).
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] o [4];
    for (int r = 0; r < 4; r++) a[r] = c[24 - 8*r +: 8];
    for (int r = 0; r < 4; r++)
      o[r] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    mix_col = {o[0], o[1], o[2], o[3]};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s);
    for (int c = 0; c < 4; c++) mix_state[c*32 +: 32] = mix_col(s[c*32 +: 32]);
  endfunction

  function automatic logic [127:0] rnd128();
    rnd128 = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // One full operation: accept, 3 busy edges with garbage on value, then the result edge.
  task automatic do_op(input logic [127:0] v, input logic [127:0] exp, input string tag);
    bus_if.value              = v;
    bus_if.enableInvMixColumn = 1'b1;
    tick();
    chk({127'd0, bus_if.busy}, 128'd1, {tag, "_busy_acc"});
    bus_if.enableInvMixColumn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus_if.value = rnd128();
      tick();
      chk({126'd0, bus_if.busy, bus_if.success}, 128'd2, {tag, "_busy_run"});
    end
    tick();
    chk({126'd0, bus_if.busy, bus_if.success}, 128'd1, {tag, "_done_flags"});
    chk(bus_if.valueOut, exp, {tag, "_result"});
  endtask

  localparam logic [127:0] KV_IN  = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};
  localparam logic [127:0] KV_OUT = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};

  initial begin
    logic [127:0] x, held, a_in, b_in;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus_if.enableInvMixColumn = 1'b0;
    bus_if.value              = 128'd0;
    #1;
    chk(bus_if.valueOut, 128'd0, "reset_value");
    chk({126'd0, bus_if.busy, bus_if.success}, 128'd0, "reset_flags");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Known vector, then success must drop on the following edge
    do_op(KV_IN, KV_OUT, "known");
    tick();
    chk({127'd0, bus_if.success}, 128'd0, "known_pulse_end");
    chk(bus_if.valueOut, KV_OUT, "known_hold");

    // Async reset mid-cycle with a nonzero result present
    #1;
    reset = 1'b0;
    #1;
    chk(bus_if.valueOut, 128'd0, "async_reset_value");
    chk({126'd0, bus_if.busy, bus_if.success}, 128'd0, "async_reset_flags");
    tick();
    reset = 1'b1;
    tick();

    do_op(128'd0, 128'd0, "zeros");
    do_op({128{1'b1}}, {128{1'b1}}, "ones");

    for (int n = 0; n < 1000; n++) begin
      x = rnd128();
      do_op(mix_state(x), x, "roundtrip");
    end

    // Back-to-back: enable held, second state accepted on the success cycle
    a_in = rnd128();
    b_in = rnd128();
    bus_if.enableInvMixColumn = 1'b1;
    bus_if.value = mix_state(a_in);
    tick();
    for (int i = 1; i <= 3; i++) begin
      bus_if.value = rnd128();
      tick();
      chk({126'd0, bus_if.busy, bus_if.success}, 128'd2, "b2b_a_run");
    end
    tick();
    chk({127'd0, bus_if.success}, 128'd1, "b2b_a_success");
    chk(bus_if.valueOut, a_in, "b2b_a_result");
    bus_if.value = mix_state(b_in);
    tick();
    chk({126'd0, bus_if.busy, bus_if.success}, 128'd2, "b2b_b_accept");
    for (int i = 6; i <= 8; i++) begin
      bus_if.value = rnd128();
      tick();
      chk({126'd0, bus_if.busy, bus_if.success}, 128'd2, "b2b_b_run");
    end
    tick();
    chk({127'd0, bus_if.success}, 128'd1, "b2b_b_success");
    chk(bus_if.valueOut, b_in, "b2b_b_result");
    bus_if.enableInvMixColumn = 1'b0;
    tick();
    chk({126'd0, bus_if.busy, bus_if.success}, 128'd0, "b2b_idle");

    // Abort: reset asserted across edge N+2
    x = rnd128();
    bus_if.value = mix_state(x);
    bus_if.enableInvMixColumn = 1'b1;
    tick();
    bus_if.enableInvMixColumn = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk(bus_if.valueOut, 128'd0, "abort_value");
    chk({126'd0, bus_if.busy, bus_if.success}, 128'd0, "abort_flags");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({126'd0, bus_if.busy, bus_if.success}, 128'd0, "abort_no_success");
    end
    x = rnd128();
    do_op(mix_state(x), x, "after_abort");

    // Idle hold with enable low and value toggling
    held = bus_if.valueOut;
    chk(held, x, "idle_start");
    for (int i = 0; i < 20; i++) begin
      bus_if.value = rnd128();
      tick();
      chk(bus_if.valueOut, x, "idle_value");
      chk({126'd0, bus_if.busy, bus_if.success}, 128'd0, "idle_flags");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
